// File: rtl/inverse_sub_bytes.sv
// inverse_sub_bytes: AES-128 InvSubBytes stage, 16 parallel inverse S-box lookups registered with 1-cycle latency
module inverse_sub_bytes (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic [127:0] in,
   output logic [127:0] out,
   output logic         out_valid
);
   // Entry 0 sits at the MSB end, so the table reads in FIPS-197 row order
   localparam logic [0:255][7:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };
   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      return INV_SBOX[b];
   endfunction
   logic [127:0] sub, out_d, out_q;
   logic         valid_d, valid_q;
   for (genvar k = 0; k < 16; k++) begin : g_byte
      assign sub[8*k +: 8] = inv_sbox(in[8*k +: 8]);
   end
   always_comb begin
      out_d   = in_valid ? sub : out_q;
      valid_d = in_valid;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         out_q   <= out_d;
         valid_q <= valid_d;
      end
   end
   assign out       = out_q;
   assign out_valid = valid_q;
endmodule

// File: tb/tb_inverse_sub_bytes.sv
// tb_inverse_sub_bytes: directed and random checks of inverse_sub_bytes against a GF(2^8) arithmetic model
module tb_inverse_sub_bytes;
   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         in_valid = 1'b0;
   logic [127:0] in = '0;
   logic [127:0] out;
   logic         out_valid;
   int           checks = 0;
   int           errors = 0;

   inverse_sub_bytes dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in(in),
      .out(out), .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
      logic [15:0] t;
      t = {x, x} << n;
      return t[15:8];
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p ^= a;
         a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] ginv(input logic [7:0] a);
      for (int x = 1; x < 256; x++)
         if (gmul(a, 8'(x)) == 8'h01) return 8'(x);
      return 8'h00;
   endfunction

   function automatic logic [7:0] ref_sbox(input logic [7:0] b);
      logic [7:0] x;
      x = ginv(b);
      return x ^ rotl(x, 1) ^ rotl(x, 2) ^ rotl(x, 3) ^ rotl(x, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] ref_inv_sbox(input logic [7:0] b);
      return ginv(rotl(b, 1) ^ rotl(b, 3) ^ rotl(b, 6) ^ 8'h05);
   endfunction

   function automatic logic [127:0] ref_state(input logic [127:0] s);
      logic [127:0] r;
      for (int k = 0; k < 16; k++) r[8*k +: 8] = ref_inv_sbox(s[8*k +: 8]);
      return r;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [127:0] d);
      @(negedge clk);
      in_valid = v;
      in = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [127:0] exp_out;
      logic [127:0] d;
      logic         v;
      chk("anchor_model_00", {120'h0, ref_inv_sbox(8'h00)}, 128'h52);
      chk("anchor_model_63", {120'h0, ref_inv_sbox(8'h63)}, 128'h00);
      drive(1'b1, 128'h0123456789abcdef0123456789abcdef);
      chk("pre_reset_out", out, ref_state(128'h0123456789abcdef0123456789abcdef));
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_out", out, '0);
      chk("async_reset_valid", {127'h0, out_valid}, 128'h0);
      in_valid = 1'b1;
      in = '1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_hold_out", out, '0);
      chk("reset_hold_valid", {127'h0, out_valid}, 128'h0);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b1;
      drive(1'b0, '0);
      drive(1'b0, '0);
      chk("idle_out", out, '0);
      chk("idle_valid", {127'h0, out_valid}, 128'h0);
      drive(1'b1, 128'h7a9f102789d5f50b2beffd9f3dca4ea7);
      chk("c1_r1_out", out, 128'hbd6e7c3df2b5779e0b61216e8b10b689);
      chk("c1_r1_valid", {127'h0, out_valid}, 128'h1);
      drive(1'b1, 128'h5411f4b56bd9700e96a0902fa1bb9aa1);
      chk("c1_r2_out", out, 128'hfde3bad205e5d0d73547964ef1fe37f1);
      chk("c1_r2_valid", {127'h0, out_valid}, 128'h1);
      drive(1'b1, 128'h63cab7040953d051cd60e0e7ba70e18c);
      chk("c1_fin_out", out, 128'h00102030405060708090a0b0c0d0e0f0);
      chk("c1_fin_valid", {127'h0, out_valid}, 128'h1);
      drive(1'b1, {16{8'h00}});
      chk("all00_out", out, {16{8'h52}});
      drive(1'b1, {16{8'hff}});
      chk("allff_out", out, {16{8'h7d}});
      drive(1'b0, '0);
      chk("hold_out", out, {16{8'h7d}});
      chk("hold_valid", {127'h0, out_valid}, 128'h0);
      drive(1'b0, 128'h1);
      chk("hold2_out", out, {16{8'h7d}});
      for (int b = 0; b < 256; b++) begin
         drive(1'b1, {16{8'(b)}});
         chk($sformatf("table_%02h", b), out, {16{ref_inv_sbox(8'(b))}});
         chk($sformatf("fwd_%02h", b), {120'h0, ref_sbox(out[127:120])}, {120'h0, 8'(b)});
         chk($sformatf("table_valid_%02h", b), {127'h0, out_valid}, 128'h1);
      end
      exp_out = {16{ref_inv_sbox(8'hff)}};
      for (int i = 0; i < 60; i++) begin
         v = 1'($urandom_range(0, 1));
         d = {$urandom, $urandom, $urandom, $urandom};
         drive(v, d);
         if (v) exp_out = ref_state(d);
         chk($sformatf("rand_out_%0d", i), out, exp_out);
         chk($sformatf("rand_valid_%0d", i), {127'h0, out_valid}, {127'h0, v});
      end
      drive(1'b1, 128'hdeadbeefcafef00d0011223344556677);
      #2 rst_n = 1'b0;
      #1;
      chk("midstream_reset_out", out, '0);
      chk("midstream_reset_valid", {127'h0, out_valid}, 128'h0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 128'h7a9f102789d5f50b2beffd9f3dca4ea7);
      chk("post_reset_out", out, 128'hbd6e7c3df2b5779e0b61216e8b10b689);
      chk("post_reset_valid", {127'h0, out_valid}, 128'h1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
